// File: rtl/adder_mult_sequencer_pkg.sv
// ============================================================================
// Module : adder_mult_sequencer_pkg
// Brief  : Shared state encodings and sizes for the shift-and-add multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_mult_sequencer_pkg;

  localparam int WIDTH  = 8;
  localparam int PROD_W = 16;

  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_8bit.sv
// ============================================================================
// Module : full_adder_8bit
// Brief  : 8-bit ripple-carry adder, no carry-in, carry-out exported.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module full_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       cout,
  output logic [7:0] s
);

  logic [8:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[8];

endmodule

`default_nettype wire

// File: rtl/adder_mult_sequencer.sv
// ============================================================================
// Module : adder_mult_sequencer
// Brief  : 8x8 unsigned shift-and-add multiplier reusing one 8-bit adder
//          over 8 add/shift steps; fixed 17-cycle latency, one-cycle done.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_mult_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import adder_mult_sequencer_pkg::*;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Partial product: the multiplicand only when the current multiplier LSB is set.
  assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

  full_adder_8bit u_adder (
    .a    (r_acc_hi),
    .b    (w_add_b),
    .cout (w_cout),
    .s    (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_mcand  <= a;
            r_acc_lo <= b;
            r_acc_hi <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_acc_hi <= w_sum;
          r_c      <= w_cout;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Carry drops into the top of acc_hi; consumed multiplier bit falls out.
          {r_c, r_acc_hi, r_acc_lo} <= {1'b0, r_c, r_acc_hi, r_acc_lo[WIDTH-1:1]};
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_ADD;
          end
        end
        ST_DONE: begin
          product <= {r_acc_hi, r_acc_lo};
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
